// File: rtl/ifetch_sequencer_pkg.sv
// rtl/ifetch_sequencer_pkg.sv - shared widths, opcodes and state encoding for the fetch sequencer
package ifetch_sequencer_pkg;

   localparam int ADDR_W  = 16;
   localparam int INSTR_W = 28;
   localparam int OPC_W   = 4;
   localparam int DELAY_W = 24;

   localparam logic [OPC_W-1:0] OPC_NOP = 4'h0;
   localparam logic [OPC_W-1:0] OPC_JMP = 4'h1;
   localparam logic [OPC_W-1:0] OPC_BLE = 4'h2;
   localparam logic [OPC_W-1:0] OPC_STO = 4'h3;
   localparam logic [OPC_W-1:0] OPC_ADD = 4'h4;
   localparam logic [OPC_W-1:0] OPC_VGA = 4'h5;
   localparam logic [OPC_W-1:0] OPC_LED = 4'h6;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DELAY = 2'd2
   } state_e;

endpackage

// File: rtl/ifetch_sequencer_delay_counter.sv
// rtl/ifetch_sequencer_delay_counter.sv - loadable down-counter timing NOP stalls
// done_o flags the last stall cycle (count==1); clear beats load beats decrement.
module delay_counter #(
   parameter int W = 24
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clear_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         done_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign done_o = (count_q == W'(1));

endmodule

// File: rtl/ifetch_sequencer.sv
// rtl/ifetch_sequencer.sv - PC owner and fetch FSM; absorbs NOP delays, hands other instructions to execute
module ifetch_sequencer #(
   parameter int                ADDR_W   = ifetch_sequencer_pkg::ADDR_W,
   parameter int                INSTR_W  = ifetch_sequencer_pkg::INSTR_W,
   parameter int                OPC_W    = ifetch_sequencer_pkg::OPC_W,
   parameter int                DELAY_W  = ifetch_sequencer_pkg::DELAY_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               iRun,
   output logic [ADDR_W-1:0]  oAddress,
   input  logic [INSTR_W-1:0] iInstruction,
   output logic [INSTR_W-1:0] oInstruction,
   output logic               oInstrValid,
   input  logic               iExecReady,
   input  logic               iBranchTaken,
   input  logic [ADDR_W-1:0]  iBranchTarget,
   output logic               oDelayBusy
);

   import ifetch_sequencer_pkg::*;

   state_e               state_q;
   logic [ADDR_W-1:0]    pc_q;
   logic [INSTR_W-1:0]   instr_q;
   logic                 valid_q;
   logic                 busy_q;

   logic [OPC_W-1:0]     opcode;
   logic [DELAY_W-1:0]   delay_field;
   logic                 is_nop;
   logic                 fetch_go;
   logic                 cnt_load;
   logic                 cnt_dec;
   logic                 cnt_done;

   assign opcode      = iInstruction[INSTR_W-1 -: OPC_W];
   assign delay_field = iInstruction[DELAY_W-1:0];
   assign is_nop      = (opcode == OPC_NOP);
   assign fetch_go    = !iBranchTaken && (state_q == FETCH) && iRun;
   assign cnt_load    = fetch_go && is_nop && (delay_field != '0);
   assign cnt_dec     = !iBranchTaken && (state_q == DELAY);

   delay_counter #(.W(DELAY_W)) u_delay (
      .clk_i      (Clock),
      .rst_i      (Reset),
      .clear_i    (iBranchTaken),
      .load_i     (cnt_load),
      .load_val_i (delay_field),
      .dec_i      (cnt_dec),
      .done_o     (cnt_done)
   );

   // A redirect overrides every state; the word fetched in that cycle is dropped.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else if (iBranchTaken) begin
         state_q <= FETCH;
         pc_q    <= iBranchTarget;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            FETCH: begin
               if (iRun) begin
                  pc_q <= pc_q + 1'b1;
                  if (!is_nop) begin
                     instr_q <= iInstruction;
                     valid_q <= 1'b1;
                     state_q <= HOLD;
                  end else if (delay_field != '0) begin
                     busy_q  <= 1'b1;
                     state_q <= DELAY;
                  end
               end
            end
            HOLD: begin
               if (iExecReady) begin
                  valid_q <= 1'b0;
                  state_q <= FETCH;
               end
            end
            DELAY: begin
               if (cnt_done) begin
                  busy_q  <= 1'b0;
                  state_q <= FETCH;
               end
            end
            default: state_q <= FETCH;
         endcase
      end
   end

   assign oAddress     = pc_q;
   assign oInstruction = instr_q;
   assign oInstrValid  = valid_q;
   assign oDelayBusy   = busy_q;

endmodule

// File: tb/tb_ifetch_sequencer.sv
// tb/tb_ifetch_sequencer.sv - directed self-checking bench for ifetch_sequencer
module tb_ifetch_sequencer;
   import ifetch_sequencer_pkg::*;

   logic                Clock = 1'b0;
   logic                Reset = 1'b1;
   logic                iRun = 1'b0;
   logic [ADDR_W-1:0]   oAddress;
   logic [INSTR_W-1:0]  iInstruction;
   logic [INSTR_W-1:0]  oInstruction;
   logic                oInstrValid;
   logic                iExecReady = 1'b0;
   logic                iBranchTaken = 1'b0;
   logic [ADDR_W-1:0]   iBranchTarget = '0;
   logic                oDelayBusy;

   logic [INSTR_W-1:0]  rom [0:65535];
   int errors = 0;
   int checks = 0;

   ifetch_sequencer dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .iRun          (iRun),
      .oAddress      (oAddress),
      .iInstruction  (iInstruction),
      .oInstruction  (oInstruction),
      .oInstrValid   (oInstrValid),
      .iExecReady    (iExecReady),
      .iBranchTaken  (iBranchTaken),
      .iBranchTarget (iBranchTarget),
      .oDelayBusy    (oDelayBusy)
   );

   always #5 Clock = ~Clock;
   assign iInstruction = rom[oAddress];

   function automatic logic [INSTR_W-1:0] mk(input logic [OPC_W-1:0] op, input logic [DELAY_W-1:0] f);
      return {op, f};
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      iRun = 1'b0;
      iExecReady = 1'b0;
      iBranchTaken = 1'b0;
      iBranchTarget = '0;
      for (int i = 0; i < 16; i++) rom[i] = mk(OPC_LED, 24'h000F00 + 24'(i));
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (oAddress !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want %h", oAddress, 16'h0000); end
      checks++; if (oInstrValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", oInstrValid); end
      checks++; if (oInstruction !== 28'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", oInstruction); end
      checks++; if (oDelayBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", oDelayBusy); end
   endtask

   task automatic test_issue();
      do_reset();
      rom[0] = mk(OPC_STO, 24'h000005);
      rom[1] = mk(OPC_ADD, 24'h000007);
      iRun = 1'b1; iExecReady = 1'b1;
      tick();
      checks++; if (oInstrValid !== 1'b1 || oInstruction !== 28'h3000005) begin errors++; $display("FAIL issue_first: valid %b instr %h want 1 3000005", oInstrValid, oInstruction); end
      checks++; if (oAddress !== 16'h0001) begin errors++; $display("FAIL issue_addr_a: got %h want 0001", oAddress); end
      tick();
      checks++; if (oInstrValid !== 1'b0 || oAddress !== 16'h0001) begin errors++; $display("FAIL issue_handshake: valid %b addr %h want 0 0001", oInstrValid, oAddress); end
      tick();
      checks++; if (oInstrValid !== 1'b1 || oInstruction !== 28'h4000007 || oAddress !== 16'h0002) begin errors++; $display("FAIL issue_second: valid %b instr %h addr %h want 1 4000007 0002", oInstrValid, oInstruction, oAddress); end
   endtask

   task automatic test_nop_delay();
      int busy_cnt;
      bit bad;
      do_reset();
      rom[0] = mk(OPC_NOP, 24'd3);
      rom[1] = mk(OPC_ADD, 24'h000011);
      iRun = 1'b1; iExecReady = 1'b1;
      busy_cnt = 0; bad = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (oDelayBusy === 1'b1) busy_cnt++;
         if (oInstrValid !== 1'b0 || oAddress !== 16'h0001) bad = 1;
      end
      checks++; if (busy_cnt !== 3) begin errors++; $display("FAIL nop_busy_cycles: got %0d want 3", busy_cnt); end
      checks++; if (bad) begin errors++; $display("FAIL nop_stall_outputs: valid/addr changed during stall, now %b %h want 0 0001", oInstrValid, oAddress); end
      tick();
      checks++; if (oInstrValid !== 1'b1 || oInstruction !== 28'h4000011 || oAddress !== 16'h0002) begin errors++; $display("FAIL nop_then_add: valid %b instr %h addr %h want 1 4000011 0002", oInstrValid, oInstruction, oAddress); end
   endtask

   task automatic test_nop_zero();
      do_reset();
      rom[0] = mk(OPC_NOP, 24'd0);
      rom[1] = mk(OPC_STO, 24'h000022);
      iRun = 1'b1; iExecReady = 1'b1;
      tick();
      checks++; if (oAddress !== 16'h0001 || oDelayBusy !== 1'b0 || oInstrValid !== 1'b0) begin errors++; $display("FAIL nop0_step: addr %h busy %b valid %b want 0001 0 0", oAddress, oDelayBusy, oInstrValid); end
      tick();
      checks++; if (oInstrValid !== 1'b1 || oInstruction !== 28'h3000022 || oAddress !== 16'h0002) begin errors++; $display("FAIL nop0_next: valid %b instr %h addr %h want 1 3000022 0002", oInstrValid, oInstruction, oAddress); end
   endtask

   task automatic test_hold();
      bit bad;
      do_reset();
      rom[0] = mk(OPC_VGA, 24'h0000AA);
      rom[1] = mk(OPC_LED, 24'h0000BB);
      iRun = 1'b1; iExecReady = 1'b0;
      tick();
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (oInstrValid !== 1'b1 || oInstruction !== 28'h50000AA || oAddress !== 16'h0001) bad = 1;
      end
      checks++; if (bad) begin errors++; $display("FAIL hold_stable: valid %b instr %h addr %h want 1 50000AA 0001", oInstrValid, oInstruction, oAddress); end
      iExecReady = 1'b1;
      tick();
      checks++; if (oInstrValid !== 1'b0 || oAddress !== 16'h0001) begin errors++; $display("FAIL hold_release: valid %b addr %h want 0 0001", oInstrValid, oAddress); end
      tick();
      checks++; if (oInstrValid !== 1'b1 || oInstruction !== 28'h60000BB || oAddress !== 16'h0002) begin errors++; $display("FAIL hold_resume: valid %b instr %h addr %h want 1 60000BB 0002", oInstrValid, oInstruction, oAddress); end
   endtask

   task automatic test_branch_delay();
      do_reset();
      rom[0] = mk(OPC_NOP, 24'd2000);
      rom[6] = mk(OPC_STO, 24'h000066);
      iRun = 1'b1; iExecReady = 1'b0;
      tick(); tick(); tick();
      checks++; if (oDelayBusy !== 1'b1) begin errors++; $display("FAIL brd_busy: got %b want 1", oDelayBusy); end
      iBranchTaken = 1'b1; iBranchTarget = 16'h0006;
      tick();
      iBranchTaken = 1'b0;
      checks++; if (oDelayBusy !== 1'b0 || oAddress !== 16'h0006 || oInstrValid !== 1'b0) begin errors++; $display("FAIL brd_redirect: busy %b addr %h valid %b want 0 0006 0", oDelayBusy, oAddress, oInstrValid); end
      tick();
      checks++; if (oInstrValid !== 1'b1 || oInstruction !== 28'h3000066 || oAddress !== 16'h0007 || oDelayBusy !== 1'b0) begin errors++; $display("FAIL brd_fetch: valid %b instr %h addr %h busy %b want 1 3000066 0007 0", oInstrValid, oInstruction, oAddress, oDelayBusy); end
   endtask

   task automatic test_branch_hold();
      do_reset();
      rom[0] = mk(OPC_ADD, 24'h000001);
      rom[6] = mk(OPC_JMP, 24'h000006);
      iRun = 1'b1; iExecReady = 1'b0;
      tick();
      iExecReady = 1'b1; iBranchTaken = 1'b1; iBranchTarget = 16'h0006;
      tick();
      iBranchTaken = 1'b0;
      checks++; if (oInstrValid !== 1'b0 || oAddress !== 16'h0006) begin errors++; $display("FAIL brh_redirect: valid %b addr %h want 0 0006", oInstrValid, oAddress); end
      tick();
      checks++; if (oInstrValid !== 1'b1 || oInstruction !== 28'h1000006 || oAddress !== 16'h0007) begin errors++; $display("FAIL brh_no_dup: valid %b instr %h addr %h want 1 1000006 0007", oInstrValid, oInstruction, oAddress); end
   endtask

   task automatic test_branch_fetch();
      do_reset();
      rom[0] = mk(OPC_STO, 24'h000001);
      iRun = 1'b1; iExecReady = 1'b1;
      iBranchTaken = 1'b1; iBranchTarget = 16'h0009;
      tick();
      iBranchTaken = 1'b0;
      checks++; if (oAddress !== 16'h0009 || oInstrValid !== 1'b0 || oInstruction !== 28'h0) begin errors++; $display("FAIL brf_discard: addr %h valid %b instr %h want 0009 0 0000000", oAddress, oInstrValid, oInstruction); end
   endtask

   task automatic test_wrap();
      do_reset();
      rom[16'hFFFF] = mk(OPC_LED, 24'h000ABC);
      iBranchTaken = 1'b1; iBranchTarget = 16'hFFFF;
      tick();
      iBranchTaken = 1'b0;
      checks++; if (oAddress !== 16'hFFFF) begin errors++; $display("FAIL wrap_setup: got %h want FFFF", oAddress); end
      iRun = 1'b1; iExecReady = 1'b1;
      tick();
      checks++; if (oAddress !== 16'h0000 || oInstrValid !== 1'b1 || oInstruction !== 28'h6000ABC) begin errors++; $display("FAIL wrap: addr %h valid %b instr %h want 0000 1 6000ABC", oAddress, oInstrValid, oInstruction); end
   endtask

   task automatic test_async_reset();
      do_reset();
      rom[0] = mk(OPC_STO, 24'h000123);
      rom[1] = mk(OPC_NOP, 24'd2000);
      iRun = 1'b1; iExecReady = 1'b1;
      tick(); tick(); tick();
      checks++; if (oDelayBusy !== 1'b1 || oInstruction !== 28'h3000123 || oAddress !== 16'h0002) begin errors++; $display("FAIL areset_setup: busy %b instr %h addr %h want 1 3000123 0002", oDelayBusy, oInstruction, oAddress); end
      #2;
      Reset = 1'b1;
      #1;
      checks++; if (oDelayBusy !== 1'b0 || oInstruction !== 28'h0 || oAddress !== 16'h0000 || oInstrValid !== 1'b0) begin errors++; $display("FAIL areset_async: busy %b instr %h addr %h valid %b want 0 0000000 0000 0", oDelayBusy, oInstruction, oAddress, oInstrValid); end
      @(negedge Clock);
      Reset = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) rom[i] = mk(OPC_LED, 24'h00FFFF);
      test_reset();
      test_issue();
      test_nop_delay();
      test_nop_zero();
      test_hold();
      test_branch_delay();
      test_branch_hold();
      test_branch_fetch();
      test_wrap();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
